// File: rtl/apb_reg_slave_if.sv
// apb_reg_slave_if: APB3 bus bundle between the CPU-side requester and apb_reg_slave.
interface apb_reg_slave_if #(
  parameter int ADDR_WIDTH     = 12,
  parameter int APB_DATA_WIDTH = 32
);
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB3 front-end turning bus transfers into single-cycle register bank writes and reads.
// Define APB_REG_WAIT_EN to insert WAIT_CYCLES access-phase wait states on every transfer.
module apb_reg_slave #(
  parameter int                    REG_NUM        = 8,
  parameter int                    ADDR_WIDTH     = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 12'h000,
  parameter int                    WAIT_CYCLES    = 2,
  parameter int                    APB_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  apb_reg_slave_if.slave             apb,
  output logic                       reg_apb_wen,
  output logic [APB_DATA_WIDTH-1:0]  reg_apb_wdata,
  output logic [$clog2(REG_NUM)-1:0] reg_apb_addr,
  input  logic [APB_DATA_WIDTH-1:0]  r0_in,
  input  logic [APB_DATA_WIDTH-1:0]  r1_in,
  input  logic [APB_DATA_WIDTH-1:0]  r2_in,
  input  logic [APB_DATA_WIDTH-1:0]  r3_in,
  input  logic [APB_DATA_WIDTH-1:0]  r4_in,
  input  logic [APB_DATA_WIDTH-1:0]  r5_in,
  input  logic [APB_DATA_WIDTH-1:0]  r6_in,
  input  logic [APB_DATA_WIDTH-1:0]  r7_in
);
  localparam int IDX_W = $clog2(REG_NUM);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(BASE_ADDR) + (ADDR_WIDTH+1)'(REG_NUM * 4);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                      pready_q, pready_d;
  logic                      pslverr_q, pslverr_d;
  logic                      reg_apb_wen_q, reg_apb_wen_d;
  logic [APB_DATA_WIDTH-1:0] reg_apb_wdata_q, reg_apb_wdata_d;
  logic [IDX_W-1:0]          reg_apb_addr_q, reg_apb_addr_d;

`ifdef APB_REG_WAIT_EN
  localparam int WAIT_LOAD = WAIT_CYCLES;
  localparam int CNT_W     = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Wait states compiled out: every transfer answers in its first access cycle.
  localparam int WAIT_LOAD = 0 * WAIT_CYCLES;
`endif

  logic [ADDR_WIDTH-1:0]     dec_addr;
  logic                      dec_wr;
  logic                      dec_err;
  logic [IDX_W-1:0]          dec_idx;
  logic [APB_DATA_WIDTH-1:0] bank_arr [8];
  logic [APB_DATA_WIDTH-1:0] rd_val;
  logic                      respond;

  assign bank_arr = '{r0_in, r1_in, r2_in, r3_in, r4_in, r5_in, r6_in, r7_in};

  // In IDLE decode the live bus address; in ACCESS decode the latched one.
  always_comb begin
    dec_addr = (state_q == IDLE) ? apb.paddr  : paddr_q;
    dec_wr   = (state_q == IDLE) ? apb.pwrite : pwrite_q;
    dec_err  = (dec_addr[1:0] != 2'b00) ||
               ({1'b0, dec_addr} < {1'b0, BASE_ADDR}) ||
               ({1'b0, dec_addr} >= LIMIT);
    dec_idx  = IDX_W'((dec_addr - BASE_ADDR) >> 2);
    // The bank commits a pending strobe on the same edge prdata loads, so bypass it.
    if (dec_err)
      rd_val = '0;
    else if (reg_apb_wen_q && (reg_apb_addr_q == dec_idx))
      rd_val = reg_apb_wdata_q;
    else
      rd_val = bank_arr[dec_idx];
  end

  always_comb begin
    state_d         = state_q;
    paddr_d         = paddr_q;
    pwdata_d        = pwdata_q;
    pwrite_d        = pwrite_q;
    prdata_d        = prdata_q;
    pready_d        = pready_q;
    pslverr_d       = pslverr_q;
    reg_apb_wen_d   = 1'b0;
    reg_apb_wdata_d = reg_apb_wdata_q;
    reg_apb_addr_d  = reg_apb_addr_q;
    respond         = 1'b0;
`ifdef APB_REG_WAIT_EN
    cnt_d           = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          paddr_d  = apb.paddr;
          pwdata_d = apb.pwdata;
          pwrite_d = apb.pwrite;
          state_d  = ACCESS;
          respond  = (WAIT_LOAD == 0);
`ifdef APB_REG_WAIT_EN
          cnt_d    = CNT_W'(WAIT_LOAD);
`endif
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
`ifdef APB_REG_WAIT_EN
          cnt_d     = '0;
`endif
        end
`ifdef APB_REG_WAIT_EN
        else if (cnt_q != '0) begin
          cnt_d   = cnt_q - 1'b1;
          respond = (cnt_q == CNT_W'(1));
        end
`endif
        else if (apb.penable && pready_q) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          if (pwrite_q && !dec_err) begin
            reg_apb_wen_d   = 1'b1;
            reg_apb_wdata_d = pwdata_q;
            reg_apb_addr_d  = dec_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (respond) begin
      pready_d  = 1'b1;
      pslverr_d = dec_err;
      if (!dec_wr)
        prdata_d = rd_val;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      paddr_q         <= '0;
      pwdata_q        <= '0;
      pwrite_q        <= 1'b0;
      prdata_q        <= '0;
      pready_q        <= 1'b0;
      pslverr_q       <= 1'b0;
      reg_apb_wen_q   <= 1'b0;
      reg_apb_wdata_q <= '0;
      reg_apb_addr_q  <= '0;
`ifdef APB_REG_WAIT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      paddr_q         <= paddr_d;
      pwdata_q        <= pwdata_d;
      pwrite_q        <= pwrite_d;
      prdata_q        <= prdata_d;
      pready_q        <= pready_d;
      pslverr_q       <= pslverr_d;
      reg_apb_wen_q   <= reg_apb_wen_d;
      reg_apb_wdata_q <= reg_apb_wdata_d;
      reg_apb_addr_q  <= reg_apb_addr_d;
`ifdef APB_REG_WAIT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

  assign apb.prdata    = prdata_q;
  assign apb.pready    = pready_q;
  assign apb.pslverr   = pslverr_q;
  assign reg_apb_wen   = reg_apb_wen_q;
  assign reg_apb_wdata = reg_apb_wdata_q;
  assign reg_apb_addr  = reg_apb_addr_q;
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: randomized APB traffic against a register-map reference model with a strobe scoreboard.
module tb_apb_reg_slave;
  localparam int          AW   = 12;
  localparam int          DW   = 32;
  localparam int          NREG = 8;
  localparam logic [11:0] BASE = 12'h000;
`ifdef APB_REG_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  apb_reg_slave_if #(.ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) apb ();

  logic          wen;
  logic [DW-1:0] wdata;
  logic [2:0]    waddr;
  logic [DW-1:0] bank [NREG];
  logic          preset_en = 1'b0;
  logic [2:0]    preset_idx = '0;
  logic [DW-1:0] preset_val = '0;

  apb_reg_slave #(
    .REG_NUM(NREG), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
    .WAIT_CYCLES(2), .APB_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .resetn(resetn), .apb(apb),
    .reg_apb_wen(wen), .reg_apb_wdata(wdata), .reg_apb_addr(waddr),
    .r0_in(bank[0]), .r1_in(bank[1]), .r2_in(bank[2]), .r3_in(bank[3]),
    .r4_in(bank[4]), .r5_in(bank[5]), .r6_in(bank[6]), .r7_in(bank[7])
  );

  // Downstream register bank: APB strobe wins over the bench's preset port.
  always @(posedge clk) begin
    if (wen) bank[waddr] <= wdata;
    else if (preset_en) bank[preset_idx] <= preset_val;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: register contents, last read value and expected strobes.
  logic [31:0] mdl_mem [NREG];
  logic [31:0] mdl_last_rd = '0;
  typedef struct { int due; logic [2:0] idx; logic [31:0] data; } strobe_t;
  strobe_t exp_q[$];

  function automatic bit addr_bad(input logic [11:0] a);
    int ai = int'(a);
    int bi = int'(BASE);
    return (ai % 4 != 0) || (ai < bi) || (ai >= bi + NREG * 4);
  endfunction

  always @(negedge clk) begin
    strobe_t s;
    if (resetn) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("strobe_missing", 32'(0), 32'(1));
        void'(exp_q.pop_front());
      end
      if (wen) begin
        if (exp_q.size() == 0) chk("strobe_spurious", 32'(1), 32'(0));
        else begin
          s = exp_q.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(s.due));
          chk("strobe_idx", 32'(waddr), 32'(s.idx));
          chk("strobe_data", wdata, s.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    apb.psel = 1'b0;
    apb.penable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic preset(input int idx, input logic [31:0] val);
    idle(1);
    preset_en = 1'b1; preset_idx = 3'(idx); preset_val = val;
    @(posedge clk); #1;
    preset_en = 1'b0;
    mdl_mem[idx] = val;
  endtask

  // Starts and ends at posedge+1; the caller may chain transfers back-to-back.
  task automatic apb_xfer(input bit wr, input logic [11:0] addr, input logic [31:0] data);
    bit          bad = addr_bad(addr);
    int          idx = bad ? 0 : (int'(addr) - int'(BASE)) / 4;
    int          waits = 0;
    bit          done = 0;
    logic [31:0] exp;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = data;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (apb.pready) begin
        done = 1;
        chk("wait_states", 32'(waits), 32'(WAITS));
        chk("pslverr", 32'(apb.pslverr), 32'(bad));
        if (!wr) begin
          exp = bad ? 32'h0 : mdl_mem[idx];
          mdl_last_rd = exp;
          chk("prdata", apb.prdata, exp);
        end else begin
          chk("prdata_hold", apb.prdata, mdl_last_rd);
          if (!bad) begin
            mdl_mem[idx] = data;
            exp_q.push_back('{due: cyc + 1, idx: 3'(idx), data: data});
          end
        end
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      chk("pready_timeout", 32'(0), 32'(1));
      apb.psel = 1'b0; apb.penable = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    int          r;
    resetn = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
    #1;
    for (int i = 0; i < NREG; i++) preset(i, $urandom);
    preset(1, 32'h0);
    preset(7, 32'h12345678);
    @(negedge clk);
    chk("rst_prdata", apb.prdata, 32'h0);
    chk("rst_pready", 32'(apb.pready), 32'(0));
    chk("rst_pslverr", 32'(apb.pslverr), 32'(0));
    chk("rst_wen", 32'(wen), 32'(0));
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_waddr", 32'(waddr), 32'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(2);

    // Directed: plain write, plain read, write then back-to-back forwarded read.
    apb_xfer(1'b1, 12'h008, 32'hDEADBEEF);
    idle(2);
    apb_xfer(1'b0, 12'h01C, 32'h0);
    idle(1);
    apb_xfer(1'b1, 12'h004, 32'hA5A5A5A5);
    apb_xfer(1'b0, 12'h004, 32'h0);
    idle(2);

    // Error transfers: out of range and unaligned, both directions.
    apb_xfer(1'b1, 12'h020, 32'h11111111);
    apb_xfer(1'b1, 12'h006, 32'h22222222);
    apb_xfer(1'b0, 12'h020, 32'h0);
    apb_xfer(1'b0, 12'h006, 32'h0);
    idle(2);

    // penable without a setup phase must be ignored.
    apb.psel = 1'b1; apb.penable = 1'b1; apb.pwrite = 1'b1; apb.paddr = 12'h00C; apb.pwdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_setup_pready", 32'(apb.pready), 32'(0));
      @(posedge clk); #1;
    end
    idle(2);

    // Abort: psel dropped in the first access cycle.
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 12'h00C; apb.pwdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pready", 32'(apb.pready), 32'(0));
    chk("abort_pslverr", 32'(apb.pslverr), 32'(0));
    @(posedge clk); #1;
    idle(4);
    apb_xfer(1'b0, 12'h00C, 32'h0);
    idle(2);

    // Asynchronous reset in the middle of an access phase.
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 12'h010; apb.pwdata = 32'h0BADCAFE;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("midrst_prdata", apb.prdata, 32'h0);
    chk("midrst_pready", 32'(apb.pready), 32'(0));
    chk("midrst_pslverr", 32'(apb.pslverr), 32'(0));
    chk("midrst_wen", 32'(wen), 32'(0));
    mdl_last_rd = '0;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(4);
    apb_xfer(1'b0, 12'h010, 32'h0);
    idle(1);

    // Randomized traffic, mostly in-range so forwarding and hold cases recur.
    for (int t = 0; t < 120; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE + 12'(4 * $urandom_range(0, 7));
      else if (r == 7) a = BASE + 12'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
      else             a = 12'($urandom_range(32, 4095));
      apb_xfer(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 2) == 0) idle(1);
    end

    // Read every register back through the bus.
    for (int i = 0; i < NREG; i++) apb_xfer(1'b0, BASE + 12'(4 * i), 32'h0);
    idle(4);
    chk("strobe_pending", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
- APB3 slave front-end placed directly upstream of the 8-entry APB register bank.
- Decodes CPU APB transfers into the bank's single-cycle write strobe (reg_apb_wen / reg_apb_wdata / reg_apb_addr).
- Returns read data from the bank outputs R0..R7.
- Handles pready/pslverr, address validation, abort recovery and read-after-write forwarding.

Parameters:
- REG_NUM, 8: number of 32-bit word registers; fixed at 8, matching the eight read inputs.
- ADDR_WIDTH, 12: paddr width.
- BASE_ADDR, 12'h000: byte address of R0; must be aligned to REG_NUM*4.
- WAIT_CYCLES, 2: access-phase wait states; used only when APB_REG_WAIT_EN is defined.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  APB_DATA_WIDTH  write data
- prdata  out  APB_DATA_WIDTH  read data, registered
- pready  out  1  transfer-ready, registered
- pslverr  out  1  error response, registered; valid with pready
- reg_apb_wen  out  1  one-cycle write strobe to the register bank
- reg_apb_wdata  out  APB_DATA_WIDTH  write data to the bank
- reg_apb_addr  out  $clog2(REG_NUM)  word index to the bank
- r0_in..r7_in  in  APB_DATA_WIDTH each  bank outputs R0..R7

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset resetn.
- Reset values: all outputs 0; state = IDLE; wait counter = 0; latched address/data/write = 0.
- State IDLE:
  - On psel & ~penable (setup phase), latch paddr, pwdata and pwrite.
  - Compute err = (paddr[1:0] != 0) | (paddr < BASE_ADDR) | (paddr >= BASE_ADDR + REG_NUM*4).
  - Compute idx = (paddr - BASE_ADDR) >> 2, truncated to $clog2(REG_NUM) bits.
  - Load the wait counter with WAIT_CYCLES (0 when the feature is off); go to ACCESS.
  - If the counter load value is 0, set pready = 1 at this same edge and set pslverr = err.
  - For a read, set prdata at this edge: 0 if err, otherwise the forwarded value (see forwarding).
- State ACCESS:
  - While counter != 0: decrement the counter and hold pready = 0.
  - At the edge where the counter becomes 0: set pready = 1, pslverr = err, and prdata as above.
  - Completion edge (penable & pready sampled 1): pready <= 0, pslverr <= 0, return to IDLE.
  - On a write with no err, the completion edge also sets reg_apb_wen = 1, reg_apb_wdata = latched data and reg_apb_addr = idx, for exactly one cycle.
  - prdata holds its value until the next read loads it.
- Transfer timing:
  - Zero-wait transfer: 2 APB cycles; write strobe visible in cycle 3.
  - A back-to-back setup is accepted in the cycle after completion, concurrently with the strobe cycle.
- Read-after-write forwarding:
  - Applies when reg_apb_wen = 1 in the cycle prdata is loaded and reg_apb_addr == idx.
  - In that case prdata takes reg_apb_wdata instead of the bank output, because the bank commits on that same edge.
- Error transfers: no write strobe; prdata = 0; pslverr = 1 for the single pready cycle.
- Abort: psel = 0 while in ACCESS → return to IDLE at once; pready, pslverr and the pending write are cleared; no write strobe.
- The bank gives APB writes priority over its second writer; this block never stalls on contention.
- Reset mid-transfer: everything returns to reset values immediately (asynchronous); no write strobe afterwards.
- penable asserted in IDLE without a preceding setup is ignored.

Optional Feature:
- Macro: APB_REG_WAIT_EN.
- Defined: every transfer inserts WAIT_CYCLES access-phase cycles with pready = 0 before pready rises. Total transfer = WAIT_CYCLES + 2 cycles. Error transfers also wait.
- Undefined: the counter logic is removed; all transfers are zero-wait; WAIT_CYCLES is ignored.

Test Plan:
- Write paddr 0x008, pwdata 0xDEADBEEF, zero-wait → pready = 1 in the access cycle, pslverr = 0; next cycle reg_apb_wen = 1, reg_apb_addr = 2, reg_apb_wdata = 0xDEADBEEF.
- Read paddr 0x01C with r7_in = 0x12345678 → prdata = 0x12345678 with pready; no write strobe.
- Write 0x004 = 0xA5A5A5A5, then back-to-back read 0x004 (r1_in still old value 0) → prdata = 0xA5A5A5A5 via forwarding.
- Write paddr 0x020 (out of range) and paddr 0x006 (unaligned) → pslverr = 1 with pready, reg_apb_wen never asserted, prdata = 0 on a read.
- APB_REG_WAIT_EN defined, WAIT_CYCLES = 2 → pready low for 2 access cycles and high in the 3rd; write strobe one cycle after completion.
- Abort: drop psel during a wait state → IDLE, no strobe. Separately, assert resetn = 0 mid-access → all outputs 0 and no strobe after release.
